// File: rtl/top_mlp_inference.sv
// Two-layer fixed-point MLP inference core. Layer 1 produces one hidden neuron per clock through
// an 11-cycle pipeline ending in an activation LUT. Layer 2 accumulates the 10 outputs serially.
module top_mlp_inference #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 10,
    parameter int W      = 16,
    parameter int FRAC   = 8,
    parameter int L1_LAT = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enableLayer3,
    input  logic                we,
    input  logic [W-1:0]        waddr,
    input  logic [W-1:0]        wdata,
    input  logic [N_IN*W-1:0]   inputs,
    input  logic [N_IN*W-1:0]   weights1,
    input  logic [N_OUT*W-1:0]  weights2,
    output logic [W-1:0]        output0,
    output logic [W-1:0]        output1,
    output logic [W-1:0]        output2,
    output logic [W-1:0]        output3,
    output logic [W-1:0]        output4,
    output logic [W-1:0]        output5,
    output logic [W-1:0]        output6,
    output logic [W-1:0]        output7,
    output logic [W-1:0]        output8,
    output logic [W-1:0]        output9
);
    localparam int PW     = 2 * W;
    localparam int ACC1_W = 42;
    localparam int ACC2_W = 40;
    localparam int SAT_W  = 48;
    localparam int GRP    = 28;
    localparam int NGRP   = (N_IN + GRP - 1) / GRP;
    localparam int DLY    = L1_LAT - 5;
    localparam logic signed [W-1:0] SAT_POS = 16'sh7FFF;
    localparam logic signed [W-1:0] SAT_NEG = 16'sh8000;

    function automatic logic signed [PW-1:0] mul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic signed [W-1:0] sat_shift(input logic signed [SAT_W-1:0] v);
        logic signed [SAT_W-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_W'(SAT_POS)) return SAT_POS;
        if (s < SAT_W'(SAT_NEG)) return SAT_NEG;
        return s[W-1:0];
    endfunction

    logic signed [PW-1:0]     prod_p0_d [N_IN];
    logic signed [PW-1:0]     prod_p0_q [N_IN];
    logic signed [ACC1_W-1:0] psum_p1_d [NGRP];
    logic signed [ACC1_W-1:0] psum_p1_q [NGRP];
    logic signed [ACC1_W-1:0] sum_p2_d, sum_p2_q;
    logic signed [W-1:0]      pre_p3_d, pre_p3_q;
    logic signed [W-1:0]      h_p4_d, h_p4_q;
    logic signed [W-1:0]      dly_d [DLY];
    logic signed [W-1:0]      dly_q [DLY];
    logic signed [ACC2_W-1:0] acc_d [N_OUT];
    logic signed [ACC2_W-1:0] acc_q [N_OUT];
    logic signed [W-1:0]      out_d [N_OUT];
    logic signed [W-1:0]      out_q [N_OUT];
    logic [W-1:0]             lut_mem [2**W];

    // LUT writes ignore reset so the table can be loaded while the core is held idle.
    always_ff @(posedge clk) begin
        if (we) lut_mem[waddr] <= wdata;
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++)
            prod_p0_d[i] = mul(inputs[i*W +: W], weights1[i*W +: W]);
        for (int g = 0; g < NGRP; g++) begin
            psum_p1_d[g] = '0;
            for (int m = 0; m < GRP; m++)
                if (g * GRP + m < N_IN)
                    psum_p1_d[g] = psum_p1_d[g] + ACC1_W'(prod_p0_q[g*GRP+m]);
        end
        sum_p2_d = '0;
        for (int g = 0; g < NGRP; g++)
            sum_p2_d = sum_p2_d + psum_p1_q[g];
        pre_p3_d = sat_shift(SAT_W'(sum_p2_q));
        // The signed pre-activation indexes the table as an unsigned address (-1 -> 0xFFFF).
        h_p4_d   = lut_mem[$unsigned(pre_p3_q)];
        dly_d[0] = h_p4_q;
        for (int d = 1; d < DLY; d++)
            dly_d[d] = dly_q[d-1];
        for (int k = 0; k < N_OUT; k++) begin
            acc_d[k] = acc_q[k];
            out_d[k] = out_q[k];
            if (enableLayer3)
                out_d[k] = sat_shift(SAT_W'(acc_q[k]));
            else
                acc_d[k] = acc_q[k] + ACC2_W'(mul(dly_q[DLY-1], weights2[k*W +: W]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) prod_p0_q[i] <= '0;
            for (int g = 0; g < NGRP; g++) psum_p1_q[g] <= '0;
            sum_p2_q <= '0;
            pre_p3_q <= '0;
            h_p4_q   <= '0;
            for (int d = 0; d < DLY; d++) dly_q[d] <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                acc_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            prod_p0_q <= prod_p0_d;
            psum_p1_q <= psum_p1_d;
            sum_p2_q  <= sum_p2_d;
            pre_p3_q  <= pre_p3_d;
            h_p4_q    <= h_p4_d;
            dly_q     <= dly_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
        end
    end

    assign output0 = out_q[0];
    assign output1 = out_q[1];
    assign output2 = out_q[2];
    assign output3 = out_q[3];
    assign output4 = out_q[4];
    assign output5 = out_q[5];
    assign output6 = out_q[6];
    assign output7 = out_q[7];
    assign output8 = out_q[8];
    assign output9 = out_q[9];

endmodule

// File: tb/tb_top_mlp_inference.sv
// Directed bench for top_mlp_inference: expected outputs come from a behavioural model and a
// scoreboard queue, compared with immediate assertions when the outputs are read out.
module tb_top_mlp_inference;
    localparam int N_IN  = 784;
    localparam int N_OUT = 10;
    localparam int W     = 16;
    localparam int LAT   = 11;

    logic                clk = 1'b0;
    logic                reset;
    logic                enableLayer3;
    logic                we;
    logic [W-1:0]        waddr;
    logic [W-1:0]        wdata;
    logic [N_IN*W-1:0]   inputs;
    logic [N_IN*W-1:0]   weights1;
    logic [N_OUT*W-1:0]  weights2;
    logic [W-1:0]        output0, output1, output2, output3, output4;
    logic [W-1:0]        output5, output6, output7, output8, output9;
    logic [W-1:0]        outs [N_OUT];

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] lut_model [65536];

    top_mlp_inference dut (
        .clk(clk), .reset(reset), .enableLayer3(enableLayer3), .we(we),
        .waddr(waddr), .wdata(wdata), .inputs(inputs), .weights1(weights1),
        .weights2(weights2),
        .output0(output0), .output1(output1), .output2(output2), .output3(output3),
        .output4(output4), .output5(output5), .output6(output6), .output7(output7),
        .output8(output8), .output9(output9)
    );

    assign outs[0] = output0;
    assign outs[1] = output1;
    assign outs[2] = output2;
    assign outs[3] = output3;
    assign outs[4] = output4;
    assign outs[5] = output5;
    assign outs[6] = output6;
    assign outs[7] = output7;
    assign outs[8] = output8;
    assign outs[9] = output9;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] sat16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [W-1:0] model_h(input logic [W-1:0] in_val,
                                             input logic [W-1:0] w1_val, input int nel);
        longint p;
        logic [W-1:0] pre;
        p   = longint'($signed(in_val)) * longint'($signed(w1_val));
        pre = sat16((p * longint'(nel)) >>> 8);
        return lut_model[pre];
    endfunction

    task automatic lut_wr(input logic [W-1:0] a, input logic [W-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        lut_model[a] = d;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset        = 1'b0;
        enableLayer3 = 1'b0;
        weights1     = '0;
        weights2     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_cycle(input int c, input logic [W-1:0] in_val,
                               input logic [W-1:0] w1_val, input bit w1_all, input int n1,
                               input logic [W-1:0] w2_val, input int w2_elem,
                               input int w2s, input int n2);
        inputs   = {N_IN{in_val}};
        weights1 = '0;
        weights2 = '0;
        if (c < n1) begin
            if (w1_all) weights1 = {N_IN{w1_val}};
            else        weights1[W-1:0] = w1_val;
        end
        if (c >= w2s && c < w2s + n2) begin
            if (w2_elem < 0) weights2 = {N_OUT{w2_val}};
            else             weights2[w2_elem*W +: W] = w2_val;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic readout(input string tag);
        logic [W-1:0] saved [N_OUT];
        weights1     = '0;
        weights2     = '0;
        enableLayer3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enableLayer3 = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (exp_q.size() == 0) begin
                saved[k] = '0;
                check($sformatf("%s_sb_empty%0d", tag, k), 16'hDEAD, 16'h0000);
            end else begin
                saved[k] = exp_q.pop_front();
                check($sformatf("%s_out%0d", tag, k), outs[k], saved[k]);
            end
        end
        // Outputs must hold while enableLayer3 is low, even with activity on the datapath.
        weights1 = {N_IN{16'h0100}};
        weights2 = {N_OUT{16'h0100}};
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        weights1 = '0;
        weights2 = '0;
        for (int k = 0; k < N_OUT; k++)
            check($sformatf("%s_hold%0d", tag, k), outs[k], saved[k]);
    endtask

    task automatic run_case(input string tag, input bit do_reset, input logic [W-1:0] in_val,
                            input logic [W-1:0] w1_val, input bit w1_all, input int n1,
                            input logic [W-1:0] w2_val, input int w2_elem,
                            input int w2s, input int n2);
        int lo, hi, overlap, total;
        logic [W-1:0] h, w;
        longint v;
        if (do_reset) pulse_reset();
        lo      = (w2s > LAT) ? w2s : LAT;
        hi      = (w2s + n2 < LAT + n1) ? w2s + n2 : LAT + n1;
        overlap = (hi > lo) ? hi - lo : 0;
        h       = model_h(in_val, w1_val, w1_all ? N_IN : 1);
        for (int k = 0; k < N_OUT; k++) begin
            w = (w2_elem < 0 || k == w2_elem) ? w2_val : 16'h0000;
            v = longint'(overlap) * longint'($signed(h)) * longint'($signed(w));
            exp_q.push_back(sat16(v >>> 8));
        end
        total = ((w2s + n2 > LAT + n1) ? w2s + n2 : LAT + n1) + 2;
        for (int c = 0; c < total; c++)
            drive_cycle(c, in_val, w1_val, w1_all, n1, w2_val, w2_elem, w2s, n2);
        readout(tag);
    endtask

    initial begin
        reset        = 1'b0;
        enableLayer3 = 1'b0;
        we           = 1'b0;
        waddr        = '0;
        wdata        = '0;
        inputs       = '0;
        weights1     = '0;
        weights2     = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N_OUT; k++)
            check($sformatf("rst_out%0d", k), outs[k], 16'h0000);

        // Identity entries for every address the directed cases touch, written under reset.
        for (int a = 0; a < 512; a++)          lut_wr(16'(a), 16'(a));
        for (int a = 'h7E00; a < 'h8200; a++)  lut_wr(16'(a), 16'(a));
        for (int a = 'hFE00; a < 'h10000; a++) lut_wr(16'(a), 16'(a));
        reset = 1'b1;
        @(negedge clk);

        run_case("single",  1, 16'h0100, 16'h0100, 0, 1,   16'h0200, 3,  11, 1);
        run_case("lat10",   1, 16'h0100, 16'h0100, 0, 1,   16'h0200, 3,  10, 1);
        run_case("lat12",   1, 16'h0100, 16'h0100, 0, 1,   16'h0200, 3,  12, 1);
        run_case("sat_pos", 1, 16'h7FFF, 16'h7FFF, 1, 200, 16'h7FFF, -1, 11, 200);
        run_case("sat_neg", 1, 16'h7FFF, 16'h8001, 1, 200, 16'h7FFF, -1, 11, 200);

        lut_wr(16'hFF00, 16'h0050);
        run_case("neg_addr", 1, 16'h0100, 16'hFF00, 0, 1, 16'h0100, 0, 11, 1);

        // Reset in the middle of accumulation with the layer-1 pipeline full.
        for (int c = 0; c < 14; c++)
            drive_cycle(c, 16'h0100, 16'h0100, 0, 14, 16'h0200, 3, 11, 3);
        reset = 1'b0;
        #1;
        for (int k = 0; k < N_OUT; k++)
            check($sformatf("midrst_out%0d", k), outs[k], 16'h0000);
        weights1 = '0;
        weights2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_case("rerun", 0, 16'h0100, 16'h0100, 0, 1, 16'h0200, 3, 0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_mlp_inference.md
Name: top_mlp_inference

Overview:
- Fixed-point two-layer neural-network inference core: 784 inputs, 200 hidden neurons, 10 outputs.
- Layer 1 computes one hidden neuron per clock as a full 784-wide dot product, then applies an activation function.
- The activation function is a 64K-entry lookup table loaded over a write port.
- Layer 2 accumulates the 10 output neurons serially, one hidden value per clock.
- Sits between the image/weight streaming logic and the classifier readout.

Parameters:
- N_IN, 784, number of input activations and layer-1 weights per hidden neuron.
- N_OUT, 10, number of output neurons.
- W, 16, data width in bits; all data is signed two's complement.
- FRAC, 8, fractional bits (Q7.8) used to rescale products.
- L1_LAT, 11, clock cycles from weights1 presentation to alignment of the resulting hidden value with weights2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enableLayer3  in  1  freezes layer-2 accumulation and drives the results to the outputs.
- we  in  1  activation-LUT write enable.
- waddr  in  16  LUT write address.
- wdata  in  16  LUT write data.
- inputs  in  N_IN*W  input vector; element j is bits [16j+15:16j].
- weights1  in  N_IN*W  layer-1 weights for the current hidden neuron; same packing as inputs.
- weights2  in  N_OUT*W  layer-2 weights, one per output neuron; element k is bits [16k+15:16k].
- output0..output9  out  16 each  signed output neuron values.

Behaviour:
- Reset: while reset is low, every pipeline register, every layer-2 accumulator and output0..9 are held at 0. LUT contents are not cleared.
- LUT writes are independent of reset. When we=1 at a clock edge, LUT[waddr] <= wdata; this also works while reset is asserted.
- LUT address: the 16-bit two's-complement pre-activation value used as an unsigned index. Example: pre-activation -1 reads LUT[0xFFFF].
- Layer 1, every cycle:
  - pre = sum over j of inputs[j]*weights1[j], with 32-bit products and an accumulator of at least 42 bits.
  - The sum is arithmetically shifted right by FRAC bits, then saturated to [-32768, 32767].
  - The result addresses the LUT (synchronous read) to give hidden value h.
- Layer-1 pipeline: product registers, registered adder tree, saturation stage and LUT read, padded with delay registers to exactly L1_LAT=11 cycles.
  - The h produced from weights1 sampled at edge t is the layer-2 multiplicand at edge t+11.
  - The pipeline runs every cycle with no stall and no valid flag.
- Layer 2: while enableLayer3=0, at each edge acc[k] <= acc[k] + h*weights2[k] for k=0..9.
  - Full 32-bit product; each accumulator is at least 40 bits.
  - Zero weights2 contribute nothing, so pipeline fill and drain are harmless.
- Output: at each edge with enableLayer3=1:
  - Accumulators hold their value.
  - outputk <= saturate16(acc[k] >>> FRAC).
  - outputk registers change only on such edges and otherwise hold their value.
- Mid-operation reset: clears the accumulators, pipeline and outputs at once. Operation restarts cleanly after release, with LUT data kept.
- Simultaneous we and inference: allowed. A read of the address being written returns the old data.

Test Plan:
- LUT load under reset: reset=0; write LUT[a]=a for all 65536 addresses; release reset; one-hot inference (below) returns identity values, confirming writes took effect during reset.
- Single path: identity LUT, all inputs 0x0100; weights1 cycle 0 has element0=0x0100 and the rest 0, other cycles 0; weights2 element3=0x0200 only at cycle 11, else 0; after 20 cycles assert enableLayer3 -> output3=0x0200, all other outputs 0.
- Latency check: same as single path but weights2 placed at cycle 10 or 12 -> output3=0; confirms exact 11-cycle alignment.
- Saturation: identity LUT, inputs and weights1 all 0x7FFF -> pre-activation 0x7FFF; weights2=0x7FFF for 200 aligned cycles -> every output=0x7FFF. Repeat with weights1=0x8001 -> every output=0x8000.
- Negative address: LUT[0xFF00]=0x0050, inputs 0x0100, weights1 element0=0xFF00 (-1.0); weights2 aligned=0x0100 -> output0=0x0050.
- Reset mid-run: assert reset during accumulation, release, rerun the single-path test -> output3=0x0200 with no residue; LUT contents intact.
